// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle.
module sm_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       oper,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state_q, state_d, oper_q, oper_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d, sa_q, sa_d, done_q, done_d, dz_q, dz_d;
  logic               a_neg, b_neg, dz, ge;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic [WIDTH:0]     mul_sum, rs;
  logic [2*WIDTH-1:0] mul_step, div_step, prod;

  assign a_neg    = oper[0] & srcA[WIDTH-1];
  assign b_neg    = oper[0] & srcB[WIDTH-1];
  assign a_mag    = a_neg ? -srcA : srcA;
  assign b_mag    = b_neg ? -srcB : srcB;
  // m_q holds the multiplicand (multiply) or divisor magnitude (divide)
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  assign rs       = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ge       = rs >= {1'b0, m_q};
  assign div_step = {WIDTH'(ge ? rs - {1'b0, m_q} : rs), acc_q[WIDTH-2:0], ge};
  assign prod     = neg_q ? -acc_q : acc_q;
  assign quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem      = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign dz       = oper_q[1] && m_q == '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oper_d  = oper_q;
    a_d     = a_q;
    m_d     = m_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CALC;
        cnt_d   = CW'(WIDTH);
        oper_d  = oper;
        a_d     = srcA;
        m_d     = oper[1] ? b_mag : a_mag;
        acc_d   = {{WIDTH{1'b0}}, oper[1] ? a_mag : b_mag};
        neg_d   = a_neg ^ b_neg;
        sa_d    = a_neg;
        dz_d    = 1'b0;
      end else begin
        hi_d = hiWe ? wd : hi_q;
        lo_d = loWe ? wd : lo_q;
      end
    end else if (state_q == CALC) begin
      cnt_d   = cnt_q - CW'(1);
      acc_d   = oper_q[1] ? div_step : mul_step;
      state_d = cnt_q == CW'(1) ? FIX : CALC;
    end else begin
      state_d = IDLE;
      done_d  = 1'b1;
      dz_d    = dz;
      hi_d    = dz ? a_q : oper_q[1] ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d    = dz ? '1 : oper_q[1] ? quo : prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      oper_q  <= '0;
      a_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oper_q  <= oper_d;
      a_q     <= a_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign divZero = dz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
endmodule

// File: tb/tb_sm_muldiv.sv
// tb_sm_muldiv: randomized and directed checks of sm_muldiv at WIDTH=32 and WIDTH=8
// against an arithmetic reference model.
module tb_sm_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, hiWe = 1'b0, loWe = 1'b0;
  logic [1:0] oper = 2'b00;
  logic [31:0] srcA = '0, srcB = '0, wd = '0;
  logic busy, done, divZero;
  logic [31:0] hi, lo;
  logic start8 = 1'b0, hiWe8 = 1'b0, loWe8 = 1'b0;
  logic [1:0] oper8 = 2'b00;
  logic [7:0] srcA8 = '0, srcB8 = '0, wd8 = '0;
  logic busy8, done8, divZero8;
  logic [7:0] hi8, lo8;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  sm_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .oper(oper), .srcA(srcA), .srcB(srcB),
    .hiWe(hiWe), .loWe(loWe), .wd(wd), .busy(busy), .done(done), .divZero(divZero),
    .hi(hi), .lo(lo)
  );

  sm_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .oper(oper8), .srcA(srcA8), .srcB(srcB8),
    .hiWe(hiWe8), .loWe(loWe8), .wd(wd8), .busy(busy8), .done(done8), .divZero(divZero8),
    .hi(hi8), .lo(lo8)
  );

  // Reference: plain signed/unsigned arithmetic on 64-bit integers.
  function automatic void model(input int w, input logic [1:0] op, input longint a, input longint b,
                                output longint ehi, output longint elo, output logic edz);
    longint m, h, ua, ub, sa, sb, p, q, r;
    m  = (longint'(1) << w) - 1;
    h  = longint'(1) << (w - 1);
    ua = a & m;
    ub = b & m;
    sa = (ua >= h) ? ua - (m + 1) : ua;
    sb = (ub >= h) ? ub - (m + 1) : ub;
    edz = 1'b0;
    if (!op[1]) begin
      p   = op[0] ? sa * sb : ua * ub;
      ehi = (p >> w) & m;
      elo = p & m;
    end else if (ub == 0) begin
      edz = 1'b1;
      ehi = ua;
      elo = m;
    end else begin
      q   = op[0] ? sa / sb : ua / ub;
      r   = op[0] ? sa % sb : ua % ub;
      ehi = r & m;
      elo = q & m;
    end
  endfunction

  task automatic do_op32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit b2b, input bit inj, input string tag);
    longint ehi, elo;
    logic edz;
    int n, bc;
    model(32, op, a, b, ehi, elo, edz);
    if (!b2b) @(negedge clk);
    start = 1'b1; oper = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (divZero !== 1'b0) begin errs++; $display("FAIL %s dz_clear got=%b exp=0", tag, divZero); end
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 60) begin
      if (busy === 1'b1) bc++;
      if (inj && n == 5) begin
        start = 1'b1; hiWe = 1'b1; wd = 32'h1234; oper = 2'b00; srcA = 32'h5; srcB = 32'h7;
      end else begin
        start = 1'b0; hiWe = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; hiWe = 1'b0;
    checks++;
    if (n != 33) begin errs++; $display("FAIL %s latency got=%0d exp=33", tag, n); end
    checks++;
    if (bc != 33) begin errs++; $display("FAIL %s busy_cycles got=%0d exp=33", tag, bc); end
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL %s busy_at_done got=%b exp=0", tag, busy); end
    checks++;
    if (hi !== 32'(ehi)) begin errs++; $display("FAIL %s hi got=%h exp=%h", tag, hi, 32'(ehi)); end
    checks++;
    if (lo !== 32'(elo)) begin errs++; $display("FAIL %s lo got=%h exp=%h", tag, lo, 32'(elo)); end
    checks++;
    if (divZero !== edz) begin errs++; $display("FAIL %s divZero got=%b exp=%b", tag, divZero, edz); end
  endtask

  task automatic do_op8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input string tag);
    longint ehi, elo;
    logic edz;
    int n;
    model(8, op, a, b, ehi, elo, edz);
    @(negedge clk);
    start8 = 1'b1; oper8 = op; srcA8 = a; srcB8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 9) begin errs++; $display("FAIL %s latency8 got=%0d exp=9", tag, n); end
    checks++;
    if (hi8 !== 8'(ehi)) begin errs++; $display("FAIL %s hi8 got=%h exp=%h", tag, hi8, 8'(ehi)); end
    checks++;
    if (lo8 !== 8'(elo)) begin errs++; $display("FAIL %s lo8 got=%h exp=%h", tag, lo8, 8'(elo)); end
    checks++;
    if (divZero8 !== edz) begin errs++; $display("FAIL %s divZero8 got=%b exp=%b", tag, divZero8, edz); end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, done, divZero} !== 3'b000) begin errs++; $display("FAIL reset_flags got=%b exp=000", {busy, done, divZero}); end
    checks++;
    if ({hi, lo} !== 64'h0) begin errs++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    checks++;
    if ({busy8, hi8, lo8} !== 17'h0) begin errs++; $display("FAIL reset_w8 got=%h exp=0", {busy8, hi8, lo8}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu;
    do_op32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "multu_max");
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin errs++; $display("FAIL multu_const got=%h exp=fffffffe00000001", {hi, lo}); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errs++; $display("FAIL done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_signed;
    do_op32(2'b01, -32'sd3, 32'd7, 1'b0, 1'b0, "mult_neg");
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin errs++; $display("FAIL mult_const got=%h exp=ffffffffffffffeb", {hi, lo}); end
    do_op32(2'b11, -32'sd7, 32'd2, 1'b0, 1'b0, "div_neg");
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errs++; $display("FAIL div_const got=%h exp=fffffffffffffffd", {hi, lo}); end
    do_op32(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, "divu");
    checks++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin errs++; $display("FAIL divu_const got=%h exp=000000020000000e", {hi, lo}); end
  endtask

  task automatic test_corner;
    do_op32(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_ovf");
    checks++;
    if ({divZero, hi, lo} !== {1'b0, 32'h0, 32'h80000000}) begin errs++; $display("FAIL div_ovf_const got=%h exp=0000000080000000", {divZero, hi, lo}); end
    do_op32(2'b10, 32'd5, 32'd0, 1'b0, 1'b0, "divu_zero");
    checks++;
    if ({divZero, hi, lo} !== {1'b1, 32'd5, 32'hFFFFFFFF}) begin errs++; $display("FAIL dz_const got=%h exp=100000005ffffffff", {divZero, hi, lo}); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (divZero !== 1'b1) begin errs++; $display("FAIL dz_hold got=%b exp=1", divZero); end
    do_op32(2'b11, 32'h12345678, 32'd0, 1'b0, 1'b0, "div_zero_signed");
  endtask

  task automatic test_mt;
    logic [31:0] old_lo;
    old_lo = lo;
    @(negedge clk);
    hiWe = 1'b1; wd = 32'h1234;
    @(posedge clk); #1;
    hiWe = 1'b0;
    checks++;
    if (hi !== 32'h1234) begin errs++; $display("FAIL mthi got=%h exp=00001234", hi); end
    checks++;
    if (lo !== old_lo) begin errs++; $display("FAIL mthi_lo_kept got=%h exp=%h", lo, old_lo); end
    @(negedge clk);
    hiWe = 1'b1; loWe = 1'b1; wd = 32'hCAFEF00D;
    @(posedge clk); #1;
    hiWe = 1'b0; loWe = 1'b0;
    checks++;
    if ({hi, lo} !== {2{32'hCAFEF00D}}) begin errs++; $display("FAIL mt_both got=%h exp=cafef00dcafef00d", {hi, lo}); end
  endtask

  task automatic test_busy_ignore;
    do_op32(2'b01, 32'hFFFF0001, 32'h00030005, 1'b0, 1'b1, "busy_ignore");
  endtask

  task automatic test_back_to_back;
    do_op32(2'b00, 32'd12345, 32'd678, 1'b0, 1'b0, "b2b_first");
    do_op32(2'b11, -32'sd1000, 32'd33, 1'b1, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; oper = 2'b01; srcA = -32'sd5; srcB = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (busy !== 1'b1 || {hi, lo} == 64'h0) begin errs++; $display("FAIL pre_reset got busy=%b hilo=%h exp busy=1 hilo!=0", busy, {hi, lo}); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, divZero} !== 3'b000) begin errs++; $display("FAIL mid_reset_flags got=%b exp=000", {busy, done, divZero}); end
    checks++;
    if ({hi, lo} !== 64'h0) begin errs++; $display("FAIL mid_reset_hilo got=%h exp=0", {hi, lo}); end
    @(negedge clk);
    rst_n = 1'b1;
    do_op32(2'b01, -32'sd5, 32'd9, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [1:0] op;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) b = -b;
      do_op32(op, a, b, 1'b0, 1'b0, $sformatf("rand32_%0d", i));
    end
  endtask

  task automatic test_width8;
    do_op8(2'b00, 8'hFF, 8'hFF, "w8_multu");
    checks++;
    if ({hi8, lo8} !== 16'hFE01) begin errs++; $display("FAIL w8_multu_const got=%h exp=fe01", {hi8, lo8}); end
    do_op8(2'b11, 8'h80, 8'h03, "w8_div");
    checks++;
    if ({hi8, lo8} !== 16'hFED6) begin errs++; $display("FAIL w8_div_const got=%h exp=fed6", {hi8, lo8}); end
    do_op8(2'b11, 8'h80, 8'hFF, "w8_ovf");
    for (int i = 0; i < 16; i++)
      do_op8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 255)), $sformatf("rand8_%0d", i));
  endtask

  initial begin
    test_reset;
    test_multu;
    test_signed;
    test_corner;
    test_mt;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_width8;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sm_muldiv.md
# sm_muldiv

Parametrised iterative multiply/divide unit with HI/LO result registers, the multi-cycle companion to the single-cycle ALU in the schoolMIPS core. It executes MULT, MULTU, DIV and DIVU over a start/busy/done handshake in WIDTH+1 cycles. It holds results in architectural HI/LO registers, which software reads and writes directly (MFHI/MFLO/MTHI/MTLO). The core stalls on `busy` when an instruction needs HI/LO.

## Interface
- `WIDTH`, 32: operand, HI and LO width; legal range is 2 or greater.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  launches an operation; sampled only in IDLE.
- `oper`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `srcA`  in  WIDTH  multiplicand/dividend; captured on the accepting edge.
- `srcB`  in  WIDTH  multiplier/divisor; captured on the accepting edge.
- `hiWe`  in  1  MTHI write enable.
- `loWe`  in  1  MTLO write enable.
- `wd`  in  WIDTH  MTHI/MTLO write data.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `divZero`  out  1  valid with `done`; the finished operation was a divide by zero.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- **Reset values.** Async reset drives state to IDLE and sets `hi`=`lo`=0, `busy`=`done`=`divZero`=0, all at once and without waiting for `clk`. The counter and work registers also clear.
- **States and transitions.**
  - IDLE to CALC on `start`.
  - CALC to FIX after WIDTH steps.
  - FIX to IDLE unconditionally.
- **IDLE behaviour.**
  - `start`=1 captures `oper`, `srcA` and `srcB`, and loads the step counter with WIDTH.
  - For signed ops, operands are converted to magnitudes and the sign flags are stored.
  - `start` has priority over `hiWe`/`loWe` on the same edge; the MT write is dropped.
  - `hiWe`/`loWe` without `start` writes `wd` to HI/LO at that edge. Both may be asserted together.
- **CALC, multiply.** Each edge performs one shift-add step on the 2*WIDTH-bit product, LSB of the multiplier first.
- **CALC, divide.** Each edge performs one restoring step: shift the {remainder, quotient} pair left and trial-subtract the divisor magnitude.
- The counter decrements every CALC edge; at 1 the state moves to FIX.
- **FIX.**
  - Multiply: the product is negated if the signs differ (MULT only). `hi` gets the upper WIDTH bits and `lo` the lower WIDTH bits.
  - Divide: `lo` gets the quotient, negated if the signs differ. `hi` gets the remainder, which takes the dividend's sign (DIV only).
  - `done` is registered high for the following cycle.
- **Divide by zero** (`srcB`=0, DIV or DIVU):
  - `lo` = all ones and `hi` = captured `srcA`, unmodified.
  - `divZero`=1 together with `done`.
  - Latency is unchanged.
- **Signed overflow.** DIV of the most-negative value by -1 gives `lo` = most-negative and `hi` = 0; no flag is raised.
- **Arithmetic.** All arithmetic is modulo 2^WIDTH per register. Magnitudes use WIDTH bits unsigned, so the most-negative magnitude is 2^(WIDTH-1).
- **While busy.**
  - `hi`/`lo` keep their previous values until FIX; work registers are separate.
  - `start`, `hiWe` and `loWe` are ignored.
- **Reset mid-operation** aborts immediately. The old HI/LO are not retained; both are 0.

## Timing
- Let E0 be the edge sampling `start`=1 in IDLE.
- `busy`=1 from after E0 through the cycle ending at edge E(WIDTH+1).
- CALC steps run on E1..E(WIDTH). FIX runs on E(WIDTH+1).
- After E(WIDTH+1), in one cycle: `busy`=0, `done`=1, and `hi`/`lo`/`divZero` are valid.
- Latency is WIDTH+1 cycles from the accepting edge to result visible.
- `done` drops after exactly one cycle; `divZero` holds until the next accepted `start` clears it.
- Back-to-back: `start` asserted in the `done` cycle is accepted, since the unit is in IDLE. The next result appears WIDTH+1 cycles later.
- An MT write is visible on `hi`/`lo` in the cycle after its edge.
- No output depends combinationally on any input.

## Test plan
- **MULTU, WIDTH=32.** 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` in the 33rd cycle after E0. `busy` is high for exactly 33 cycles.
- **Signed ops.**
  - MULT -3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - DIV -7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 100 / 7 → `lo`=14, `hi`=2.
- **Corner divides.**
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `divZero`=0.
  - DIVU 5 / 0 → `lo`=0xFFFFFFFF, `hi`=5, `divZero`=1 with `done`.
- **Handshake.**
  - `start` and `hiWe` pulses with `wd`=0x1234 at cycle 5 of a busy op are both ignored; only the original result is produced.
  - MTHI 0x1234 in IDLE → `hi`=0x1234 the next cycle.
  - `start` in the `done` cycle launches a second op.
- **Reset mid-operation.** `rst_n` low at cycle 10 of a MULT → `busy`=0, `hi`=`lo`=0 immediately without a clock edge. A new op after release completes correctly.
- **WIDTH=8.**
  - MULTU 0xFF × 0xFF → `hi`=0xFE, `lo`=0x01, `done` 9 cycles after E0.
  - DIV 0x80 / 0x03 → `lo`=0xD6, `hi`=0xFE.
